adder_digit_serial: RTL

//   Sequential digit-serial adder built around the 3-bit ripple-carry adder digit.

---
 rtl/adder_pkg.sv | 8 +
 rtl/adder_digit.sv | 26 ++
 rtl/adder_digit_serial.sv | 90 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encoding and digit width for the digit-serial adder
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DIGIT_W = 3;

endpackage

// File: rtl/adder_digit.sv
// rtl/adder_digit.sv - combinational ripple-carry digit slice
module adder_digit
  import adder_pkg::*;
#(
  parameter int W = DIGIT_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic c;

  always_comb begin
    s = '0;
    c = cin;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_digit_serial.sv
// rtl/adder_digit_serial.sv - digit-serial adder, one DIGIT-bit slice per cycle behind valid/ready
module adder_digit_serial
  import adder_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DIGIT = DIGIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             accept;

  adder_digit #(.W(DIGIT)) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .s    (dsum),
    .cout (dcout)
  );

  // A retiring result frees the block in the same cycle, so a new pair can follow directly.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_sum   = sum_sh;
  assign out_cout  = carry;

  // New digit enters at the top; after NDIG shifts the low digit has reached bit 0.
  assign sum_nxt = WIDTH'({dsum, sum_sh} >> DIGIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      a_sh  <= in_a;
      b_sh  <= in_b;
      carry <= in_cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      sum_sh <= sum_nxt;
      carry  <= dcout;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule
